// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control encodings and the E-stage control bundle.
// The optional multiply/divide fields are present only when DECODE_MULDIV_EN is defined.
package decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_FENCE  = 7'd15;
   localparam logic [6:0] OP_IMM    = 7'd19;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_R      = 7'd51;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_JAL    = 7'd111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;
   localparam logic [1:0] ALU_DEF = 2'b11;

   localparam logic [2:0] IMM_I   = 3'b000;
   localparam logic [2:0] IMM_U   = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_J   = 3'b100;
   localparam logic [2:0] IMM_DEF = 3'b111;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       jump_reg;
      logic       branch;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       rd1_src;
`ifdef DECODE_MULDIV_EN
      logic       muldiv;
      logic [2:0] funct;
`endif
   } ctrl_t;

   // Bubble and illegal-decode value: every enable low, selects at their defaults.
   localparam ctrl_t CTRL_BUBBLE = '{
      reg_write:  1'b0,
      result_src: RES_ALU,
      mem_write:  1'b0,
      jump:       1'b0,
      jump_reg:   1'b0,
      branch:     1'b0,
      alu_op:     ALU_DEF,
      alu_src:    1'b1,
`ifdef DECODE_MULDIV_EN
      rd1_src:    1'b0,
      muldiv:     1'b0,
      funct:      3'b000
`else
      rd1_src:    1'b0
`endif
   };

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Decode/E-stage bus between the pipeline front end and decode_ctrl_pipe.
// MulDivE/FunctE exist only when DECODE_MULDIV_EN is defined.
interface decode_ctrl_pipe_if #(parameter int CNT_W = 8);
   logic [31:0]      InstrD;
   logic             ValidD;
   logic             StallD;
   logic             FlushE;
   logic             HaltClr;
   logic [2:0]       ImmSrcD;
   logic             RegWriteE;
   logic [1:0]       ResultSrcE;
   logic             MemWriteE;
   logic             JumpE;
   logic             JumpRegE;
   logic             BranchE;
   logic [1:0]       ALUOpE;
   logic             ALUSrcE;
   logic             RD1SrcE;
   logic             ValidE;
   logic             IllegalE;
   logic             Halted;
   logic [CNT_W-1:0] IllegalCount;
`ifdef DECODE_MULDIV_EN
   logic             MulDivE;
   logic [2:0]       FunctE;
`endif

   modport master (
      output InstrD, ValidD, StallD, FlushE, HaltClr,
      input  ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, JumpE, JumpRegE, BranchE,
             ALUOpE, ALUSrcE, RD1SrcE, ValidE, IllegalE, Halted, IllegalCount
`ifdef DECODE_MULDIV_EN
      , input MulDivE, FunctE
`endif
   );

   modport slave (
      input  InstrD, ValidD, StallD, FlushE, HaltClr,
      output ImmSrcD, RegWriteE, ResultSrcE, MemWriteE, JumpE, JumpRegE, BranchE,
             ALUOpE, ALUSrcE, RD1SrcE, ValidE, IllegalE, Halted, IllegalCount
`ifdef DECODE_MULDIV_EN
      , output MulDivE, FunctE
`endif
   );
endinterface

// File: rtl/decode_table.sv
// Combinational opcode decode: control bundle, immediate select and illegal flag.
// With DECODE_MULDIV_EN, R-type funct7 is checked and the M-extension row is recognised.
module decode_table
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        illegal,
   output logic [2:0]  imm_src
);

   logic unused_instr;
   assign unused_instr = ^instr;

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      imm_src = IMM_DEF;
      illegal = 1'b0;
      case (instr[6:0])
         OP_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b0;
            ctrl.alu_op    = ALU_FN;
`ifdef DECODE_MULDIV_EN
            if (instr[31:25] == F7_MULDIV)
               ctrl.muldiv = 1'b1;
            else if (instr[31:25] != F7_BASE && instr[31:25] != F7_ALT)
               illegal = 1'b1;
`endif
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.alu_op     = ALU_ADD;
            imm_src         = IMM_I;
         end
         OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_FN;
            imm_src        = IMM_I;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.rd1_src   = 1'b1;
            imm_src        = IMM_U;
         end
         OP_LUI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_IMM;
            imm_src         = IMM_U;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            imm_src        = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.branch  = 1'b1;
            ctrl.alu_op  = ALU_BR;
            ctrl.alu_src = 1'b0;
            imm_src      = IMM_B;
         end
         OP_JALR: begin
            ctrl.jump_reg   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_src         = IMM_I;
         end
         OP_JAL: begin
            ctrl.jump       = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            imm_src         = IMM_J;
         end
         OP_FENCE: ;
         default: illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11)
         illegal = 1'b1;
`ifdef DECODE_MULDIV_EN
      ctrl.funct = instr[14:12];
`endif
      if (illegal) begin
         ctrl    = CTRL_BUBBLE;
         imm_src = IMM_DEF;
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode-to-E control register with illegal-instruction halt FSM and saturating counter.
// Optional MulDivE/FunctE outputs are enabled by DECODE_MULDIV_EN.
//
// state  | meaning
// S_RUN  | instructions issue into E normally
// S_HALT | illegal seen; E receives bubbles until HaltClr
module decode_ctrl_pipe
   import decode_pkg::*;
#(
   parameter int CNT_W           = 8,
   parameter int HALT_ON_ILLEGAL = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   decode_ctrl_pipe_if.slave bus
);

   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_HALT = 1'b1;
   localparam bit HALT_EN = (HALT_ON_ILLEGAL != 0);

   logic [0:0]       state;
   ctrl_t            ctrl_d;
   ctrl_t            ctrl_e;
   logic             illegal_d;
   logic [2:0]       imm_d;
   logic             valid_e;
   logic             illegal_e;
   logic [CNT_W-1:0] cnt;
   logic             update;
   logic             illegal_load;

   decode_table u_table (
      .instr   (bus.InstrD),
      .ctrl    (ctrl_d),
      .illegal (illegal_d),
      .imm_src (imm_d)
   );

   assign update       = bus.ValidD & ~bus.StallD & ~bus.FlushE & (state == S_RUN);
   assign illegal_load = update & illegal_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e    <= CTRL_BUBBLE;
         valid_e   <= 1'b0;
         illegal_e <= 1'b0;
      end else if (bus.FlushE || !bus.StallD) begin
         if (update) begin
            ctrl_e    <= ctrl_d;
            valid_e   <= 1'b1;
            illegal_e <= illegal_d;
         end else begin
            ctrl_e    <= CTRL_BUBBLE;
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
         end
      end
   end

   // HaltClr is evaluated in HALT only, so a coincident instruction is dropped (update needs RUN).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_RUN;
      else begin
         case (state)
            S_RUN:   if (illegal_load && HALT_EN) state <= S_HALT;
            S_HALT:  if (bus.HaltClr) state <= S_RUN;
            default: state <= S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (illegal_load && cnt != {CNT_W{1'b1}})
         cnt <= cnt + CNT_W'(1);
   end

   assign bus.ImmSrcD      = imm_d;
   assign bus.RegWriteE    = ctrl_e.reg_write;
   assign bus.ResultSrcE   = ctrl_e.result_src;
   assign bus.MemWriteE    = ctrl_e.mem_write;
   assign bus.JumpE        = ctrl_e.jump;
   assign bus.JumpRegE     = ctrl_e.jump_reg;
   assign bus.BranchE      = ctrl_e.branch;
   assign bus.ALUOpE       = ctrl_e.alu_op;
   assign bus.ALUSrcE      = ctrl_e.alu_src;
   assign bus.RD1SrcE      = ctrl_e.rd1_src;
   assign bus.ValidE       = valid_e;
   assign bus.IllegalE     = illegal_e;
   assign bus.Halted       = (state == S_HALT);
   assign bus.IllegalCount = cnt;
`ifdef DECODE_MULDIV_EN
   assign bus.MulDivE      = ctrl_e.muldiv;
   assign bus.FunctE       = ctrl_e.funct;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench: two instances (default, and CNT_W=2 without halt) share stimulus;
// a reference model pushes expected E-state per edge, monitors pop and compare.
module tb_decode_ctrl_pipe;

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       j;
      logic       jr;
      logic       br;
      logic [1:0] aop;
      logic       asrc;
      logic       rd1;
      logic       v;
      logic       ill;
      logic       halted;
      logic [7:0] cnt;
`ifdef DECODE_MULDIV_EN
      logic       md;
      logic [2:0] fn;
`endif
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_ctrl_pipe_if #(.CNT_W(8)) ifa ();
   decode_ctrl_pipe_if #(.CNT_W(2)) ifb ();

   decode_ctrl_pipe #(.CNT_W(8), .HALT_ON_ILLEGAL(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   decode_ctrl_pipe #(.CNT_W(2), .HALT_ON_ILLEGAL(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int   total = 0;
   int   bad   = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   exp_t m_e[2];
   bit   m_halt[2];
   int   m_cnt[2];
   int   cmax[2] = '{255, 3};
   bit   hoi[2]  = '{1'b1, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic exp_t bubble();
      exp_t b;
      b = '0;
      b.aop  = 2'd3;
      b.asrc = 1'b1;
      return b;
   endfunction

   // Reference decode straight from the opcode table.
   task automatic ref_decode(input logic [31:0] instr, output exp_t d, output bit ill,
                             output logic [2:0] imm);
      int op;
      op  = int'(instr[6:0]);
      d   = bubble();
      ill = 0;
      imm = 3'd7;
      case (op)
         51: begin
            d.rw = 1; d.asrc = 0; d.aop = 2;
`ifdef DECODE_MULDIV_EN
            if (instr[31:25] == 7'd1) d.md = 1;
            else if (instr[31:25] != 7'd0 && instr[31:25] != 7'd32) ill = 1;
`endif
         end
         3:   begin d.rw = 1; d.rs = 1; imm = 0; d.aop = 0; end
         19:  begin d.rw = 1; imm = 0; d.aop = 2; end
         23:  begin d.rw = 1; imm = 1; d.rd1 = 1; end
         55:  begin d.rw = 1; imm = 1; d.rs = 3; end
         35:  begin d.mw = 1; imm = 2; d.aop = 0; end
         99:  begin d.br = 1; imm = 3; d.aop = 1; d.asrc = 0; end
         103: begin d.jr = 1; d.rw = 1; d.rs = 2; imm = 0; end
         111: begin d.j = 1; d.rw = 1; d.rs = 2; imm = 4; end
         15:  ;
         default: ill = 1;
      endcase
      if (instr[1:0] != 2'b11) ill = 1;
`ifdef DECODE_MULDIV_EN
      d.fn = instr[14:12];
`endif
      if (ill) begin
         d   = bubble();
         imm = 3'd7;
      end
   endtask

   function automatic exp_t get_act(input int k);
      exp_t a;
      a = '0;
      if (k == 0) begin
         a.rw = ifa.RegWriteE; a.rs = ifa.ResultSrcE; a.mw = ifa.MemWriteE; a.j = ifa.JumpE;
         a.jr = ifa.JumpRegE; a.br = ifa.BranchE; a.aop = ifa.ALUOpE; a.asrc = ifa.ALUSrcE;
         a.rd1 = ifa.RD1SrcE; a.v = ifa.ValidE; a.ill = ifa.IllegalE; a.halted = ifa.Halted;
         a.cnt = ifa.IllegalCount;
`ifdef DECODE_MULDIV_EN
         a.md = ifa.MulDivE; a.fn = ifa.FunctE;
`endif
      end else begin
         a.rw = ifb.RegWriteE; a.rs = ifb.ResultSrcE; a.mw = ifb.MemWriteE; a.j = ifb.JumpE;
         a.jr = ifb.JumpRegE; a.br = ifb.BranchE; a.aop = ifb.ALUOpE; a.asrc = ifb.ALUSrcE;
         a.rd1 = ifb.RD1SrcE; a.v = ifb.ValidE; a.ill = ifb.IllegalE; a.halted = ifb.Halted;
         a.cnt = {6'b0, ifb.IllegalCount};
`ifdef DECODE_MULDIV_EN
         a.md = ifb.MulDivE; a.fn = ifb.FunctE;
`endif
      end
      return a;
   endfunction

   task automatic cmp_e(input int k, input exp_t want);
      exp_t act;
      act = get_act(k);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL e_stage dut%0d at %0t: got %h want %h", k, $time, act, want);
      end
   endtask

   initial begin : mon_a
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) cmp_e(0, q_a.pop_front());
      end
   end

   initial begin : mon_b
      forever begin
         @(posedge clk);
         #1;
         if (q_b.size() > 0) cmp_e(1, q_b.pop_front());
      end
   end

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_e[k]    = bubble();
         m_halt[k] = 0;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic step(input logic [31:0] instr, input bit v, input bit s, input bit f, input bit hc);
      exp_t       d;
      bit         ill;
      bit         nh;
      logic [2:0] imm;
      @(negedge clk);
      ifa.InstrD = instr; ifa.ValidD = v; ifa.StallD = s; ifa.FlushE = f; ifa.HaltClr = hc;
      ifb.InstrD = instr; ifb.ValidD = v; ifb.StallD = s; ifb.FlushE = f; ifb.HaltClr = hc;
      ref_decode(instr, d, ill, imm);
      for (int k = 0; k < 2; k++) begin
         nh = m_halt[k];
         if (f)
            m_e[k] = bubble();
         else if (!s) begin
            if (m_halt[k] || !v)
               m_e[k] = bubble();
            else begin
               m_e[k]     = d;
               m_e[k].v   = 1;
               m_e[k].ill = ill;
               if (ill) begin
                  if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                  if (hoi[k]) nh = 1;
               end
            end
         end
         if (m_halt[k] && hc) nh = 0;
         m_halt[k]     = nh;
         m_e[k].halted = nh;
         m_e[k].cnt    = 8'(m_cnt[k]);
         if (k == 0) q_a.push_back(m_e[k]);
         else        q_b.push_back(m_e[k]);
      end
      #1;
      chk("imm_src_a", 32'(ifa.ImmSrcD), 32'(imm));
      chk("imm_src_b", 32'(ifb.ImmSrcD), 32'(imm));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops[10] = '{7'd51, 7'd3, 7'd19, 7'd23, 7'd55, 7'd35, 7'd99, 7'd103, 7'd111, 7'd15};
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(3) == 0) return r;
      if ($urandom_range(1) == 0) r[31:25] = 7'($urandom_range(1) * 32);
      if ($urandom_range(3) == 0) r[31:25] = 7'd1;
      return {r[31:7], ops[$urandom_range(9)]};
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] addi, add, sw, ill7f, mul;
      addi  = 32'h00A00093;
      add   = 32'h002081B3;
      sw    = 32'h00112023;
      ill7f = 32'h0000007F;
      mul   = 32'h02208033;
      ifa.InstrD = '0; ifa.ValidD = 0; ifa.StallD = 0; ifa.FlushE = 0; ifa.HaltClr = 0;
      ifb.InstrD = '0; ifb.ValidD = 0; ifb.StallD = 0; ifb.FlushE = 0; ifb.HaltClr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid_a", 32'(ifa.ValidE), 0);
      chk("rst_halted_a", 32'(ifa.Halted), 0);
      chk("rst_cnt_a", 32'(ifa.IllegalCount), 0);
      chk("rst_aluop_a", 32'(ifa.ALUOpE), 3);
      rst_n = 1'b1;

      step(addi, 1, 0, 0, 0);
      repeat (3) step(add, 1, 1, 0, 0);
      step(add, 1, 1, 1, 0);
      step(add, 1, 0, 0, 0);
      step(ill7f, 1, 0, 0, 0);
      repeat (2) step(sw, 1, 0, 0, 0);
      step(sw, 1, 0, 0, 1);
      step(sw, 1, 0, 0, 0);
      step(add, 1, 0, 0, 1);
      repeat (5) step(ill7f, 1, 0, 0, 0);
      step(mul, 1, 0, 0, 1);
      step(mul, 1, 0, 0, 0);
      step(32'h00000010, 1, 0, 0, 1);

      for (int i = 0; i < 300; i++) begin
         step(rand_instr(), $urandom_range(3) != 0, $urandom_range(4) == 0,
              $urandom_range(6) == 0, $urandom_range(3) == 0);
      end

      step(addi, 1, 0, 0, 1);
      step(ill7f, 1, 0, 0, 0);
      step(sw, 1, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_halted_a", 32'(ifa.Halted), 32'(m_halt[0]));
      #2 rst_n = 1'b0;
      #1;
      chk("async_halted_a", 32'(ifa.Halted), 0);
      chk("async_cnt_a", 32'(ifa.IllegalCount), 0);
      chk("async_cnt_b", 32'(ifb.IllegalCount), 0);
      chk("async_valid_a", 32'(ifa.ValidE), 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(sw, 1, 0, 0, 0);
      step(ill7f, 1, 0, 0, 0);
      step(addi, 1, 0, 0, 0);

      repeat (2) @(negedge clk);
      chk("drain_a", 32'(q_a.size()), 0);
      chk("drain_b", 32'(q_b.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
